// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CHECK = 2'd3
    } state_e;

    // Byte offsets of the ID and timestamp words inside the responder.
    localparam int unsigned ID_OFS = 0;
    localparam int unsigned TS_OFS = 4;

endpackage

// File: rtl/sysid_checker_timer.sv
// Stall counter: counts enabled cycles and flags the one that reaches TIMEOUT.
module sysid_checker_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [15:0] count_q, count_d;

    // Clear wins over count so a new read always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expire on the TIMEOUT-th stalled cycle so read is up for exactly TIMEOUT stalls.
    assign expire_o = en_i && !clr_i && (count_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/sysid_checker.sv
// Reads the ID and timestamp words of a system-ID responder over Avalon-MM
// and compares them with the values baked in at build time.
//
// state | meaning
// IDLE  | waiting for start, results held
// RD_ID | reading offset 0 (ID word)
// RD_TS | reading offset 4 (timestamp word)
// CHECK | results valid, one-cycle done pulse
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter logic [31:0]        EXPECTED_ID = 32'd0,
    parameter logic [31:0]        EXPECTED_TS = 32'd1355713149,
    parameter int unsigned        TIMEOUT     = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_mismatch,
    output logic              ts_mismatch,
    output logic              timeout,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    localparam logic [ADDR_W-1:0] ID_ADDR = BASE_ADDR + ADDR_W'(ID_OFS);
    localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(TS_OFS);

    state_e      state_q, state_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        pass_q, pass_d;
    logic        id_mis_q, id_mis_d;
    logic        ts_mis_q, ts_mis_d;
    logic        timeout_q, timeout_d;
    logic        stall, expire, tmr_clr;

    assign read    = (state_q == RD_ID) || (state_q == RD_TS);
    assign address = (state_q == RD_TS) ? TS_ADDR : ID_ADDR;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == CHECK);
    assign stall   = read && waitrequest;

    sysid_checker_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .en_i     (stall),
        .clr_i    (tmr_clr),
        .expire_o (expire)
    );

    // Next state and results. Flags are settled on the edge into CHECK so they
    // are already valid while done is high; a word lost to timeout is never compared.
    always_comb begin
        state_d    = state_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        pass_d     = pass_q;
        id_mis_d   = id_mis_q;
        ts_mis_d   = ts_mis_q;
        timeout_d  = timeout_q;
        tmr_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_ID;
                    id_value_d = '0;
                    ts_value_d = '0;
                    pass_d     = 1'b0;
                    id_mis_d   = 1'b0;
                    ts_mis_d   = 1'b0;
                    timeout_d  = 1'b0;
                    tmr_clr    = 1'b1;
                end
            end
            RD_ID: begin
                if (!waitrequest) begin
                    id_value_d = readdata;
                    tmr_clr    = 1'b1;
                    state_d    = RD_TS;
                end else if (expire) begin
                    timeout_d  = 1'b1;
                    state_d    = CHECK;
                end
            end
            RD_TS: begin
                if (!waitrequest) begin
                    ts_value_d = readdata;
                    id_mis_d   = (id_value_q != EXPECTED_ID);
                    ts_mis_d   = (readdata != EXPECTED_TS);
                    pass_d     = (id_value_q == EXPECTED_ID) && (readdata == EXPECTED_TS);
                    state_d    = CHECK;
                end else if (expire) begin
                    id_mis_d   = (id_value_q != EXPECTED_ID);
                    timeout_d  = 1'b1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            id_value_q <= '0;
            ts_value_q <= '0;
            pass_q     <= 1'b0;
            id_mis_q   <= 1'b0;
            ts_mis_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            pass_q     <= pass_d;
            id_mis_q   <= id_mis_d;
            ts_mis_q   <= ts_mis_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pass        = pass_q;
    assign id_mismatch = id_mis_q;
    assign ts_mismatch = ts_mis_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: directed and random read sequences against a
// timing/outcome model computed from wait-state counts and returned words.
module tb_sysid_checker;

    localparam logic [31:0] BASE    = 32'hFFFF_FFFC;
    localparam logic [31:0] TS_ADDR = BASE + 32'd4;
    localparam logic [31:0] EXP_ID  = 32'd0;
    localparam logic [31:0] EXP_TS  = 32'd1355713149;
    localparam int          TO      = 8;

    logic        clock, reset_n, start, waitrequest;
    logic [31:0] readdata, address, id_value, ts_value;
    logic        read, busy, done, pass, id_mismatch, ts_mismatch, timeout;

    int checks = 0;
    int fails  = 0;

    sysid_checker #(
        .ADDR_W      (32),
        .BASE_ADDR   (BASE),
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .TIMEOUT     (TO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .address     (address),
        .read        (read),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_mismatch (id_mismatch),
        .ts_mismatch (ts_mismatch),
        .timeout     (timeout),
        .id_value    (id_value),
        .ts_value    (ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // One full sequence. wid/wts = stalled cycles before each word is returned.
    // Model: a read lasts wait+1 cycles, or TIMEOUT cycles if wait >= TIMEOUT.
    task automatic run_seq(input int wid, input int wts, input logic [31:0] did,
                           input logic [31:0] dts, input bit ign);
        int          len_id, len_ts, done_k, j;
        bit          id_cap, ts_cap;
        logic        e_to, e_idm, e_tsm, e_pass;
        logic [31:0] e_idv, e_tsv;
        id_cap = (wid < TO);
        len_id = id_cap ? wid + 1 : TO;
        ts_cap = id_cap && (wts < TO);
        len_ts = !id_cap ? 0 : (ts_cap ? wts + 1 : TO);
        done_k = 1 + len_id + len_ts;
        e_to   = !ts_cap;
        e_idm  = id_cap && (did != EXP_ID);
        e_tsm  = ts_cap && (dts != EXP_TS);
        e_pass = !e_to && !e_idm && !e_tsm;
        e_idv  = id_cap ? did : 32'd0;
        e_tsv  = ts_cap ? dts : 32'd0;

        start = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= done_k; k++) begin
            start = 1'b0;
            if (k <= len_id) begin
                j = k - 1;
                waitrequest = (j < wid);
                readdata    = waitrequest ? $urandom : did;
                chk("id_read", {31'd0, read}, 32'd1);
                chk("id_addr", address, BASE);
                chk("id_busy", {31'd0, busy}, 32'd1);
                chk("id_done", {31'd0, done}, 32'd0);
                if (k == 1) begin
                    chk("clr_flags", {28'd0, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
                    chk("clr_idv", id_value, 32'd0);
                    chk("clr_tsv", ts_value, 32'd0);
                end
            end else if (k <= len_id + len_ts) begin
                j = k - 1 - len_id;
                waitrequest = (j < wts);
                readdata    = waitrequest ? $urandom : dts;
                chk("ts_read", {31'd0, read}, 32'd1);
                chk("ts_addr", address, TS_ADDR);
                chk("ts_done", {31'd0, done}, 32'd0);
                if (ign && j == 0) start = 1'b1;
            end else begin
                waitrequest = 1'b0;
                readdata    = $urandom;
                chk("chk_read", {31'd0, read}, 32'd0);
                chk("chk_addr", address, BASE);
                chk("chk_done", {31'd0, done}, 32'd1);
                chk("chk_busy", {31'd0, busy}, 32'd1);
                chk("chk_flags", {28'd0, pass, id_mismatch, ts_mismatch, timeout},
                    {28'd0, e_pass, e_idm, e_tsm, e_to});
                chk("chk_idv", id_value, e_idv);
                chk("chk_tsv", ts_value, e_tsv);
                if (ign) start = 1'b1;
            end
            @(negedge clock);
        end
        start = 1'b0;
        waitrequest = 1'b0;
        chk("post_done", {31'd0, done}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_flags", {28'd0, pass, id_mismatch, ts_mismatch, timeout},
            {28'd0, e_pass, e_idm, e_tsm, e_to});
        chk("post_idv", id_value, e_idv);
    endtask

    initial begin
        logic [31:0] rid, rts;
        start = 1'b0;
        waitrequest = 1'b0;
        readdata = 32'd0;
        reset_n = 1'b0;
        #3;
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_addr", address, BASE);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_flags", {28'd0, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
        chk("rst_vals", id_value | ts_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_seq(0, 0, EXP_ID, EXP_TS, 1'b0);        // zero-wait pass
        run_seq(5, 5, EXP_ID, EXP_TS, 1'b0);        // 5 stalls each, done at start+13
        run_seq(0, 0, 32'h0000_0001, EXP_TS, 1'b0); // id mismatch
        run_seq(50, 0, EXP_ID, EXP_TS, 1'b0);       // stuck waitrequest on ID read
        run_seq(1, 30, 32'h1234_5678, EXP_TS, 1'b0);// timeout on TS, id still compared
        run_seq(2, 1, EXP_ID, 32'hDEAD_BEEF, 1'b1); // ignored starts, then back-to-back
        run_seq(TO - 1, TO - 1, EXP_ID, EXP_TS, 1'b0); // longest stall without timeout

        for (int n = 0; n < 20; n++) begin
            rid = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            rts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            run_seq($urandom_range(0, 10), $urandom_range(0, 10), rid, rts,
                    1'($urandom_range(0, 1)));
        end

        // Reset during an ID stall.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitrequest = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_read", {31'd0, read}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_read", {31'd0, read}, 32'd0);
        chk("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("mid_rst_addr", address, BASE);
        chk("mid_rst_flags", {28'd0, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
        chk("mid_rst_vals", id_value | ts_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        waitrequest = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            chk("after_rst_idle", {29'd0, read, busy, done}, 32'd0);
        end
        run_seq(0, 0, EXP_ID, EXP_TS, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter ADDR_W, default 32, sets the master byte-address width.
REQ-002 Parameter BASE_ADDR, default 0, is the byte address of the target system-ID responder.
REQ-003 Parameter EXPECTED_ID, default 0, is the 32-bit value expected at offset 0.
REQ-004 Parameter EXPECTED_TS, default 1355713149, is the 32-bit timestamp expected at offset 4.
REQ-005 Parameter TIMEOUT, default 255, is the maximum cycles waitrequest may stall one read (legal range 1..65535).
REQ-006 clock  in  1  single system clock; all logic is rising-edge.
REQ-007 reset_n  in  1  reset, asynchronous and active-low.
REQ-008 start  in  1  one-cycle request to run a check sequence.
REQ-009 address  out  ADDR_W  Avalon-MM master byte address.
REQ-010 read  out  1  Avalon-MM read strobe.
REQ-011 waitrequest  in  1  Avalon-MM stall from responder.
REQ-012 readdata  in  32  Avalon-MM read data, valid in the cycle read=1 and waitrequest=0.
REQ-013 busy  out  1  high from start acceptance until done.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 pass  out  1  both words matched and no timeout; held until next accepted start.
REQ-016 id_mismatch, ts_mismatch, timeout  out  1 each  sticky error flags; held until next accepted start.
REQ-017 id_value, ts_value  out  32 each  captured words; held until next accepted start.

Function
REQ-018 FSM states SHALL be IDLE, RD_ID, RD_TS, CHECK.
REQ-019 IDLE: start=1 SHALL clear pass, error flags, id_value, ts_value, timeout counter and enter RD_ID next cycle; busy=1 from that cycle.
REQ-020 start while busy=1 SHALL be ignored, no effect on state or results.
REQ-021 RD_ID: read=1, address=BASE_ADDR; on waitrequest=0 capture readdata into id_value, clear counter, enter RD_TS.
REQ-022 RD_TS: read=1, address=BASE_ADDR+4 (modulo 2^ADDR_W); on waitrequest=0 capture readdata into ts_value, enter CHECK.
REQ-023 read and address SHALL be held stable while waitrequest=1; read=0 and address=BASE_ADDR in IDLE and CHECK.
REQ-024 Timeout counter SHALL increment each cycle read=1 and waitrequest=1; reaching TIMEOUT SHALL deassert read next cycle, set timeout=1, skip remaining read, go to CHECK.
REQ-025 CHECK (one cycle): id_mismatch=(id_value!=EXPECTED_ID), ts_mismatch=(ts_value!=EXPECTED_TS) for words actually captured; pass=1 only if no flag set; done=1 for exactly this cycle; busy drops next cycle; return to IDLE.
REQ-026 Latency with zero wait states: start cycle N -> RD_ID N+1, RD_TS N+2, done N+3.
REQ-027 start asserted in the CHECK cycle SHALL be ignored; start in the cycle after done SHALL be accepted.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state IDLE, read=0, address=BASE_ADDR, busy=0, done=0, pass=0, all flags 0, id_value=0, ts_value=0, counter=0.
REQ-029 Reset mid-read SHALL drop read immediately with no done pulse; first post-reset activity requires a new start.

Structure
REQ-030 Shared package sysid_checker_pkg SHALL hold the state typedef and offset constants (ID_OFS=0, TS_OFS=4).
REQ-031 Stall counter SHALL be a sub-module sysid_checker_timer (enable, clear, TIMEOUT parameter, expire output).

Verification
REQ-032 Zero-wait responder returning 0 / 1355713149, start pulse -> done 3 cycles later, pass=1, no flags.
REQ-033 waitrequest held 5 cycles on each read -> address/read stable during stall, done at start+13, pass=1.
REQ-034 Responder returns 0x00000001 at offset 0 -> id_mismatch=1, ts_mismatch=0, pass=0, id_value=1.
REQ-035 waitrequest stuck high, TIMEOUT=8 -> read drops after 8 stalled cycles, timeout=1, pass=0, ts_value=0, one done pulse.
REQ-036 start pulsed during RD_TS and in CHECK -> ignored; start one cycle after done -> new sequence, prior results cleared.
REQ-037 reset_n low during RD_ID stall -> read=0 same cycle, all outputs reset, no done pulse.
